// File: rtl/interp_delay_buffer_if.sv
// Frame bundle for interp_delay_buffer: input frame and delay offset in, delayed frame out.
// Latency: none (wires only).
// Backpressure: producer must hold pktValid_i until it sees ready_o high on a rising edge.
interface interp_delay_buffer_if #(
   parameter int PKT_WIDTH  = 16,
   parameter int NUM_CH     = 2,
   parameter int ADDR_WIDTH = 14,
   parameter int FRAC_BITS  = 8
);
   logic [NUM_CH*PKT_WIDTH-1:0]     pkt_i;
   logic                            pktValid_i;
   logic                            clear_i;
   logic [ADDR_WIDTH+FRAC_BITS-1:0] extraDelay_i;
   logic                            ready_o;
   logic [NUM_CH*PKT_WIDTH-1:0]     pktDelayed_o;
   logic                            pktDelayedValid_o;
   logic                            overrun_o;

   modport master (
      output pkt_i, pktValid_i, clear_i, extraDelay_i,
      input  ready_o, pktDelayed_o, pktDelayedValid_o, overrun_o
   );

   modport slave (
      input  pkt_i, pktValid_i, clear_i, extraDelay_i,
      output ready_o, pktDelayed_o, pktDelayedValid_o, overrun_o
   );
endinterface

// File: rtl/interp_delay_buffer.sv
// Multi-channel circular delay line with linearly interpolated fractional read delay.
// Latency: 4 cycles from accept to pktDelayedValid_o; one frame per 5 cycles at most.
// Backpressure: ready_o only in IDLE; frames offered otherwise are dropped and flagged on overrun_o.
module interp_delay_buffer #(
   parameter int PKT_WIDTH  = 16,
   parameter int NUM_CH     = 2,
   parameter int BUF_DEPTH  = 4410,
   parameter int AVG_DELAY  = 882,
   parameter int ADDR_WIDTH = 14,
   parameter int FRAC_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   interp_delay_buffer_if.slave bus
);

   localparam int XW  = ADDR_WIDTH + FRAC_BITS;       // extraDelay_i width
   localparam int DW  = ADDR_WIDTH + FRAC_BITS + 1;   // delay arithmetic width (signed)
   localparam int AW1 = ADDR_WIDTH + 1;
   localparam int MAW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int FW  = NUM_CH * PKT_WIDTH;
   localparam int SW  = PKT_WIDTH + 1;                // sample difference width
   localparam int PW  = PKT_WIDTH + FRAC_BITS + 2;    // product width

   localparam logic signed [DW-1:0]   AVG_FX    = DW'(AVG_DELAY) << FRAC_BITS;
   localparam logic signed [DW-1:0]   MAX_FX    = DW'(BUF_DEPTH - 2) << FRAC_BITS;
   localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(BUF_DEPTH - 1);
   localparam logic [AW1-1:0]         DEPTH_X   = AW1'(BUF_DEPTH);

   // Parameter sanity: the bank must be addressable and the centre delay must leave
   // room for the older interpolation neighbour.
   if (BUF_DEPTH > (1 << ADDR_WIDTH)) begin : g_chk_depth
      $fatal(1, "interp_delay_buffer: BUF_DEPTH exceeds 2**ADDR_WIDTH");
   end
   if (AVG_DELAY > BUF_DEPTH - 2) begin : g_chk_avg
      $fatal(1, "interp_delay_buffer: AVG_DELAY exceeds BUF_DEPTH-2");
   end

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_WRITE,
      S_RD0,
      S_RD1,
      S_INTERP
   } state_t;

   state_t r_state;
   state_t w_next;

   // Control / pointer registers
   logic [ADDR_WIDTH-1:0] r_clr_cnt;
   logic [ADDR_WIDTH-1:0] r_wr;
   logic [ADDR_WIDTH-1:0] r_a0;
   logic [ADDR_WIDTH-1:0] r_di;
   logic [FRAC_BITS-1:0]  r_frac;

   // Datapath registers
   logic [FW-1:0]         r_frame;
   logic [FW-1:0]         r_s0;
   logic [FW-1:0]         r_out;
   logic                  r_out_vld;
   logic                  r_overrun;

   // Combinational nets
   logic                  w_ready;
   logic                  w_accept;
   logic signed [DW-1:0]  w_d_raw;
   logic [XW-1:0]         w_d;
   logic [ADDR_WIDTH-1:0] w_di;
   logic [FRAC_BITS-1:0]  w_frac;
   logic [ADDR_WIDTH-1:0] w_a0;
   logic [ADDR_WIDTH-1:0] w_a1;
   logic                  w_ram_we;
   logic [MAW-1:0]        w_ram_addr;
   logic [FW-1:0]         w_ram_wdata;
   logic [FW-1:0]         w_rdata;
   logic [FW-1:0]         w_y;

   assign w_ready  = (r_state == S_IDLE);
   assign w_accept = bus.pktValid_i && w_ready;

   // Centre delay plus signed LFO offset, clamped into the readable window [0, BUF_DEPTH-2].
   always_comb begin
      w_d_raw = AVG_FX + $signed({bus.extraDelay_i[XW-1], bus.extraDelay_i});
      if (w_d_raw < 0) begin
         w_d = '0;
      end else if (w_d_raw > MAX_FX) begin
         w_d = MAX_FX[XW-1:0];
      end else begin
         w_d = w_d_raw[XW-1:0];
      end
   end

   assign w_di   = w_d[FRAC_BITS +: ADDR_WIDTH];
   assign w_frac = w_d[FRAC_BITS-1:0];

   // Newer tap address: Di samples behind the slot written in WRITE, wrapping modulo BUF_DEPTH.
   always_comb begin
      if (r_wr >= r_di) begin
         w_a0 = r_wr - r_di;
      end else begin
         w_a0 = ADDR_WIDTH'(AW1'(r_wr) + DEPTH_X - AW1'(r_di));
      end
   end

   // Older neighbour sits one slot further back, wrapping 0 -> BUF_DEPTH-1.
   assign w_a1 = (r_a0 == '0) ? LAST_ADDR : (r_a0 - ADDR_WIDTH'(1));

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_CLEAR;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state: an accept takes priority over a simultaneous clear request.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_CLEAR:  if (r_clr_cnt == LAST_ADDR) w_next = S_IDLE;
         S_IDLE: begin
            if (w_accept) begin
               w_next = S_WRITE;
            end else if (bus.clear_i) begin
               w_next = S_CLEAR;
            end
         end
         S_WRITE:  w_next = S_RD0;
         S_RD0:    w_next = S_RD1;
         S_RD1:    w_next = S_INTERP;
         S_INTERP: w_next = S_IDLE;
         default:  w_next = S_CLEAR;
      endcase
   end

   // FSM outputs: the single bank port is shared by the clear sweep, the frame write and both taps.
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_addr  = MAW'(r_a0);
      w_ram_wdata = r_frame;
      case (r_state)
         S_CLEAR: begin
            w_ram_we    = 1'b1;
            w_ram_addr  = MAW'(r_clr_cnt);
            w_ram_wdata = '0;
         end
         S_WRITE: begin
            w_ram_we   = 1'b1;
            w_ram_addr = MAW'(r_wr);
         end
         S_RD0:   w_ram_addr = MAW'(r_a0);
         S_RD1:   w_ram_addr = MAW'(w_a1);
         default: w_ram_addr = MAW'(r_a0);
      endcase
   end

   // Clear sweep counter and write pointer; the pointer parks at 0 while memory is being zeroed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clr_cnt <= '0;
         r_wr      <= '0;
         r_a0      <= '0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_wr      <= '0;
               r_clr_cnt <= (r_clr_cnt == LAST_ADDR) ? '0 : (r_clr_cnt + ADDR_WIDTH'(1));
            end
            S_WRITE: begin
               // r_wr still names the slot being written, so the tap is taken from it.
               r_a0 <= w_a0;
               r_wr <= (r_wr == LAST_ADDR) ? '0 : (r_wr + ADDR_WIDTH'(1));
            end
            default: ;
         endcase
      end
   end

   // Frame capture, tap capture, output register and sticky overrun flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame   <= '0;
         r_di      <= '0;
         r_frac    <= '0;
         r_s0      <= '0;
         r_out     <= '0;
         r_out_vld <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_out_vld <= 1'b0;
         if (bus.pktValid_i && !w_ready) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_frame <= bus.pkt_i;
                  r_di    <= w_di;
                  r_frac  <= w_frac;
               end
            end
            S_RD1:    r_s0 <= w_rdata;
            S_INTERP: begin
               r_out     <= w_y;
               r_out_vld <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Per-channel bank and interpolator; all banks see the same address and strobe.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [PKT_WIDTH-1:0]        r_mem [BUF_DEPTH];
      logic [PKT_WIDTH-1:0]        r_rdata;
      logic signed [PKT_WIDTH-1:0] w_s0;
      logic signed [PKT_WIDTH-1:0] w_s1;
      logic signed [SW-1:0]        w_diff;
      logic signed [PW-1:0]        w_prod;
      logic signed [PW-1:0]        w_step;

      // Single-port synchronous bank: read data only refreshes on non-write cycles.
      always_ff @(posedge clk) begin
         if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wdata[c*PKT_WIDTH +: PKT_WIDTH];
         end else begin
            r_rdata <= r_mem[w_ram_addr];
         end
      end

      assign w_rdata[c*PKT_WIDTH +: PKT_WIDTH] = r_rdata;

      // s0 was captured in RD1; s1 is on the bank output during INTERP.
      assign w_s0   = r_s0[c*PKT_WIDTH +: PKT_WIDTH];
      assign w_s1   = r_rdata;
      assign w_diff = {w_s1[PKT_WIDTH-1], w_s1} - {w_s0[PKT_WIDTH-1], w_s0};
      assign w_prod = $signed({{(PW-SW){w_diff[SW-1]}}, w_diff})
                    * $signed({{(PW-FRAC_BITS){1'b0}}, r_frac});
      // Arithmetic shift floors toward -inf, keeping the result between s0 and s1.
      assign w_step = w_prod >>> FRAC_BITS;
      assign w_y[c*PKT_WIDTH +: PKT_WIDTH] = PKT_WIDTH'(w_s0 + w_step);
   end

   assign bus.ready_o           = w_ready;
   assign bus.pktDelayed_o      = r_out;
   assign bus.pktDelayedValid_o = r_out_vld;
   assign bus.overrun_o         = r_overrun;

endmodule
